logic_fn_exerciser: RTL
=======================

// Module: logic_fn_exerciser
// PURPOSE
//  Self-checking exerciser: the driving and checking end of a 3-input gate-lab circuit
//  implementing F = A & (B | C).
//  On start, it sweeps all 8 input combinations onto {a_out, b_out, c_out}, waits for
//  settling, samples the circuit's F, and compares it against a golden truth table.
//  Reports pass/fail, the mismatch count and the first failing vector.
//  Sits beside any NOR/NAND/AND-OR realisation of F on the lab board top level.
// PARAMETERS
//  SETTLE_CYCLES  2          clocks each vector is held before sampling (legal range 1..15)
//  GOLDEN_TT      8'hE0      expected F, indexed by {A,B,C}; bits 5,6,7 = 1
// PORTS
//  clk            in   1  system clock, rising edge
//  rst_n          in   1  asynchronous active-low reset
//  start          in   1  1-cycle request to run a sweep; honoured only in IDLE
//  abort          in   1  synchronous cancel of a running sweep
//  f_in           in   1  F returned by the circuit under test
//  a_out          out  1  drive to input A
//  b_out          out  1  drive to input B
//  c_out          out  1  drive to input C
//  busy           out  1  sweep in progress
//  done           out  1  1-cycle pulse when a sweep completes
//  pass           out  1  last completed sweep had zero mismatches
//  err_cnt        out  4  mismatches in last sweep (0..8; no overflow possible)
//  first_fail     out  1  err_cnt != 0
//  first_fail_vec out  3  {A,B,C} of first mismatch; 0 when first_fail=0
// BEHAVIOUR
//  Reset (async, rst_n=0): every output is 0; state=IDLE; vector counter vec=0.
//  FSM states:
//   IDLE   -> SETTLE on start; vec<=0; err_cnt, first_fail, first_fail_vec and pass cleared.
//   SETTLE -> SAMPLE after SETTLE_CYCLES clocks; {a,b,c}_out = vec, stable throughout.
//   SAMPLE -> one cycle; compare f_in with GOLDEN_TT[vec].
//             On mismatch: err_cnt++. If first_fail=0, latch first_fail=1 and
//             first_fail_vec=vec.
//             If vec==7 -> DONE, otherwise vec++ -> SETTLE.
//   DONE   -> IDLE after one cycle; done=1; pass = (err_cnt==0 incl. this SAMPLE).
//  busy=1 in SETTLE, SAMPLE and DONE; 0 in IDLE.
//  Latency: start sampled at edge 0 -> done high after edge 8*(SETTLE_CYCLES+1)+1
//   (25 cycles at the default SETTLE_CYCLES).
//  f_in is sampled only in SAMPLE; f_in in any other state is ignored.
//  Drive outputs: {a,b,c}_out = vec in SETTLE/SAMPLE; 3'b000 in IDLE and DONE.
//  start while busy (including the DONE cycle): ignored; no queuing.
//  abort in SETTLE/SAMPLE: next state IDLE; drives go to 0; no done pulse; pass=0;
//   err_cnt/first_fail keep their partial values. abort in IDLE/DONE has no effect.
//  start and abort together in IDLE: start wins. abort has priority whenever busy.
//  rst_n deassertion mid-sweep: block restarts in IDLE; no spurious done pulse.
//  Result outputs hold until the next accepted start or reset.
// STRUCTURE
//  Package lab_pkg:
//   - typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} exer_state_t
//   - localparam FN_A_B_OR_C_TT = 8'hE0
//   - localparam VEC_W = 3
//  Sub-module settle_timer:
//   - 4-bit down-counter; load on SETTLE entry; `expired` when it reaches 0.
//  Top level: FSM, vec counter, compare/score logic.
// TESTING
//  T1 f_in=a&(b|c), SETTLE=2, start -> done at cycle 25; pass=1, err_cnt=0, first_fail=0.
//  T2 f_in tied 0 -> err_cnt=3, first_fail_vec=3'b101, pass=0.
//  T3 f_in=a&b -> err_cnt=1, first_fail_vec=3'b101; drives step 000..111 in order.
//  T4 start pulsed again at cycles 5 and 25 -> exactly one done; second start ignored.
//  T5 abort at cycle 10 -> IDLE next cycle, drives=0, no done; restart then matches T1.
//  T6 rst_n low at cycle 12 -> all outputs 0 immediately (async); later start matches T1.

Source files
------------

// File: rtl/lab_pkg.sv
// lab_pkg: shared types and constants for the gate-lab exerciser
package lab_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} exer_state_t;
  localparam logic [7:0] FN_A_B_OR_C_TT = 8'hE0;
  localparam int VEC_W = 3;
endpackage

// File: rtl/settle_timer.sv
// settle_timer: down-counter that holds each vector for a programmable settle time
module settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       expired
);
  logic [3:0] cnt;
  // reload on entry to SETTLE, then count down and park at zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != 4'd0) cnt <= cnt - 4'd1;
  assign expired = cnt == 4'd0;
endmodule

// File: rtl/logic_fn_exerciser.sv
// logic_fn_exerciser: sweeps all {A,B,C} vectors through a circuit and scores F against a truth table
module logic_fn_exerciser import lab_pkg::*; #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [7:0] GOLDEN_TT     = FN_A_B_OR_C_TT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             f_in,
  output logic             a_out,
  output logic             b_out,
  output logic             c_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       err_cnt,
  output logic             first_fail,
  output logic [VEC_W-1:0] first_fail_vec
);
  exer_state_t state, state_nx;
  logic [VEC_W-1:0] vec;
  logic start_q, expired, last, miss, load, scoring;
  assign last = vec == VEC_W'(7);
  assign miss = f_in != GOLDEN_TT[vec];
  assign scoring = state == SAMPLE && !abort;
  assign load = (state == IDLE && start_q) || (scoring && !last);
  settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (4'(SETTLE_CYCLES - 1)),
    .expired  (expired)
  );
  // next-state: abort beats everything while the sweep is running
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start_q ? SETTLE : IDLE;
      SETTLE:  state_nx = abort ? IDLE : expired ? SAMPLE : SETTLE;
      SAMPLE:  state_nx = abort ? IDLE : last ? DONE : SETTLE;
      default: state_nx = IDLE;
    endcase
  end
  // state register; start is registered and only captured while idle, so a
  // pulse landing in any busy cycle (DONE included) is dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      start_q <= 1'b0;
    end else begin
      state   <= state_nx;
      start_q <= start && state == IDLE;
    end
  // vector stepping and scoring; results clear only when a sweep is accepted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vec            <= '0;
      err_cnt        <= '0;
      first_fail_vec <= '0;
      pass           <= 1'b0;
    end else if (state == IDLE && start_q) begin
      vec            <= '0;
      err_cnt        <= '0;
      first_fail_vec <= '0;
      pass           <= 1'b0;
    end else if (scoring) begin
      if (miss) err_cnt <= err_cnt + 4'd1;
      if (miss && err_cnt == 4'd0) first_fail_vec <= vec;
      if (last) pass <= err_cnt == 4'd0 && !miss;
      else vec <= vec + VEC_W'(1);
    end
  assign first_fail = err_cnt != 4'd0;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign {a_out, b_out, c_out} = (state == SETTLE || state == SAMPLE) ? vec : '0;
endmodule
